rx_frame_buffer: RTL and testbench
==================================

# rx_frame_buffer

Receive-side frame buffer for the tri-mode Ethernet MAC pattern-generator/checker path. It accepts byte-wide AXI-stream frames from the MAC receive interface, which cannot be backpressured. Each frame is stored with its last flag and committed only when the frame ends good and fits entirely; errored or overflowing frames are rolled back. Committed frames are presented on a backpressurable byte stream to the downstream checker, with good/dropped frame counters.

## Interface

- SIZE, 64, buffer depth in bytes; power of two, ≥4
- clk  in  1  single clock domain, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rx_valid  in  1  MAC receive byte valid; no ready, so a byte is presented exactly once
- rx_data  in  8  MAC receive byte
- rx_last  in  1  marks the final byte of a frame
- rx_user  in  1  bad-frame flag; sampled only with rx_valid && rx_last
- brx_ready  in  1  downstream ready
- brx_valid  out  1  output byte valid
- brx_data  out  8  output byte
- brx_last  out  1  output byte is the last byte of its frame
- frame_ok  out  1  one-cycle pulse: frame committed
- frame_drop  out  1  one-cycle pulse: frame discarded (rx_user or overflow)
- ok_count  out  16  saturating count of committed frames
- drop_count  out  16  saturating count of dropped frames

## Operation

- Storage: SIZE entries of 9 bits {last, data}.
- Pointers are $clog2(SIZE)+1 bits:
  - wptr_tmp: write position of the current frame
  - wptr_cmt: end of the last committed frame
  - rptr: read position
- occupancy = wptr_tmp − rptr, modulo the pointer width. Full when occupancy == SIZE. Empty when rptr == wptr_cmt.
- Write-side FSM:
  - IDLE / RECV, on rx_valid:
    - If not full: write {rx_last, rx_data} at wptr_tmp and increment wptr_tmp.
    - If rx_last && !rx_user && not full: wptr_cmt ← wptr_tmp+1, pulse frame_ok, go to IDLE.
    - If rx_last && (rx_user || full): wptr_tmp ← wptr_cmt, pulse frame_drop, go to IDLE.
    - If !rx_last && full: wptr_tmp ← wptr_cmt, go to DROP.
    - If !rx_last && not full: go to (or stay in) RECV.
  - DROP: ignore all bytes. On rx_valid && rx_last, pulse frame_drop and go to IDLE.
- A single-byte frame in IDLE commits or drops in the same cycle and stays in IDLE.
- Full is evaluated on pre-edge register values. A read in the same cycle does not create space for that cycle's write.
- Read side uses a one-stage output register:
  - If !brx_valid || brx_ready: brx_valid ← !empty. When not empty, also {brx_last, brx_data} ← mem[rptr] and rptr ← rptr+1.
  - Otherwise hold all outputs.
- Counters:
  - ok_count increments on frame_ok; drop_count increments on frame_drop.
  - Both saturate at 0xFFFF.
- Pointers wrap naturally through the extra MSB. A frame may span the physical wrap.

## Timing

- Reset (asynchronous, immediate):
  - All pointers = 0, FSM = IDLE.
  - brx_valid, brx_data, brx_last, frame_ok, frame_drop, ok_count, drop_count all 0.
  - Memory contents are not reset.
- Reset mid-frame discards the partial frame and any unread committed data. There is no spurious pulse.
- Commit latency: the last good byte is sampled at edge E, so wptr_cmt and frame_ok update at edge E. brx_valid rises at edge E+1 when the output register is idle.
- No byte of a frame is visible downstream before that frame commits.
- Throughput: 1 byte/cycle when brx_ready is held high.
- brx_data and brx_last are stable while brx_valid && !brx_ready.
- Frame_ok and frame_drop are mutually exclusive and last exactly one cycle.
- A frame of exactly SIZE bytes fits when the buffer is empty. A frame of SIZE+1 bytes is always dropped.

## Test plan

- Good frame: SIZE=64, brx_ready=1, rx bytes 0x11,0x22,0x33,0x44 (last on 0x44, rx_user=0) -> frame_ok pulses at the commit edge; brx_valid rises one cycle later; output is 0x11..0x44 with brx_last only on 0x44; ok_count=1.
- Bad frame, then good frame: 5-byte frame with rx_user=1, then 2-byte frame 0xA0,0xA1 -> frame_drop pulses and drop_count=1; only 0xA0,0xA1 appear on the output; ok_count=1.
- Overflow:
  - Setup: SIZE=16, brx_ready=0.
  - Send a 20-byte frame -> it is dropped via DROP; drop_count=1; brx_valid stays 0.
  - Then send a 16-byte frame -> it commits.
  - Then set brx_ready=1 -> exactly 16 bytes drain, with last on byte 16.
- Backpressure: 8-byte frame with brx_ready toggling every cycle -> no loss or duplication; outputs are held while stalled; 8 accepted transfers total.
- Wrap: SIZE=16, brx_ready=1, 10 back-to-back 7-byte frames with an incrementing data pattern -> all 70 bytes are output in order; ok_count=10; drop_count=0.
- Reset mid-frame: assert rst_n low after 3 of 6 bytes -> all outputs go to 0 immediately; after release, a 2-byte good frame is output correctly and ok_count=1.

Source files
------------

// File: rtl/rx_frame_buffer.sv
// Receive frame buffer: stores MAC rx bytes, commits whole good frames, rolls back
// errored/overflowing ones, and replays committed bytes on a backpressurable stream.
module rx_frame_buffer #(
  parameter int SIZE = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_last,
  input  logic        rx_user,
  input  logic        brx_ready,
  output logic        brx_valid,
  output logic [7:0]  brx_data,
  output logic        brx_last,
  output logic        frame_ok,
  output logic        frame_drop,
  output logic [15:0] ok_count,
  output logic [15:0] drop_count
);
  localparam int AW = $clog2(SIZE);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wptr_tmp_q, wptr_tmp_d;
  logic [PW-1:0]   wptr_cmt_q, wptr_cmt_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [PW-1:0]   occ;
  logic            full, empty, we, load;
  logic            ok_q, ok_d, drop_q, drop_d;
  logic            brx_valid_q, brx_valid_d;
  logic [8:0]      brx_out_q, brx_out_d;
  logic [15:0]     ok_cnt_q, ok_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [8:0]      mem [SIZE];

  assign occ   = wptr_tmp_q - rptr_q;
  assign full  = (occ == PW'(SIZE));
  assign empty = (rptr_q == wptr_cmt_q);

  // Write side: bytes land speculatively at wptr_tmp; wptr_cmt only moves on a good end.
  always_comb begin
    state_d    = state_q;
    wptr_tmp_d = wptr_tmp_q;
    wptr_cmt_d = wptr_cmt_q;
    ok_d       = 1'b0;
    drop_d     = 1'b0;
    we         = 1'b0;
    if (rx_valid) begin
      case (state_q)
        IDLE, RECV: begin
          if (!full) begin
            we         = 1'b1;
            wptr_tmp_d = wptr_tmp_q + PW'(1);
          end
          if (rx_last) begin
            state_d = IDLE;
            if (!rx_user && !full) begin
              wptr_cmt_d = wptr_tmp_q + PW'(1);
              ok_d       = 1'b1;
            end else begin
              wptr_tmp_d = wptr_cmt_q;
              drop_d     = 1'b1;
            end
          end else if (full) begin
            wptr_tmp_d = wptr_cmt_q;
            state_d    = DROP;
          end else begin
            state_d = RECV;
          end
        end
        DROP: begin
          if (rx_last) begin
            drop_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Read side: single output register, refilled whenever empty or consumed.
  always_comb begin
    load        = !brx_valid_q || brx_ready;
    brx_valid_d = brx_valid_q;
    brx_out_d   = brx_out_q;
    rptr_d      = rptr_q;
    if (load) begin
      brx_valid_d = !empty;
      if (!empty) begin
        brx_out_d = mem[rptr_q[AW-1:0]];
        rptr_d    = rptr_q + PW'(1);
      end
    end
  end

  always_comb begin
    ok_cnt_d   = ok_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (ok_d && ok_cnt_q != 16'hFFFF)     ok_cnt_d   = ok_cnt_q + 16'd1;
    if (drop_d && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (we) mem[wptr_tmp_q[AW-1:0]] <= {rx_last, rx_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wptr_tmp_q  <= '0;
      wptr_cmt_q  <= '0;
      rptr_q      <= '0;
      ok_q        <= 1'b0;
      drop_q      <= 1'b0;
      brx_valid_q <= 1'b0;
      brx_out_q   <= '0;
      ok_cnt_q    <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wptr_tmp_q  <= wptr_tmp_d;
      wptr_cmt_q  <= wptr_cmt_d;
      rptr_q      <= rptr_d;
      ok_q        <= ok_d;
      drop_q      <= drop_d;
      brx_valid_q <= brx_valid_d;
      brx_out_q   <= brx_out_d;
      ok_cnt_q    <= ok_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign brx_valid  = brx_valid_q;
  assign brx_last   = brx_out_q[8];
  assign brx_data   = brx_out_q[7:0];
  assign frame_ok   = ok_q;
  assign frame_drop = drop_q;
  assign ok_count   = ok_cnt_q;
  assign drop_count = drop_cnt_q;
endmodule

// File: tb/tb_rx_frame_buffer.sv
// Scoreboard bench for rx_frame_buffer: good frames push expected bytes, the
// output monitor pops and compares every accepted transfer.
module tb_rx_frame_buffer;
  localparam int SIZE = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0, rx_last = 1'b0, rx_user = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        brx_ready = 1'b1;
  logic        brx_valid, brx_last, frame_ok, frame_drop;
  logic [7:0]  brx_data;
  logic [15:0] ok_count, drop_count;

  int          n_chk = 0, n_err = 0, xfers = 0;
  logic [8:0]  sb_q[$];
  logic        prev_stall = 1'b0;
  logic [8:0]  prev_out = '0;

  rx_frame_buffer #(.SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last), .rx_user(rx_user),
    .brx_ready(brx_ready), .brx_valid(brx_valid), .brx_data(brx_data), .brx_last(brx_last),
    .frame_ok(frame_ok), .frame_drop(frame_drop),
    .ok_count(ok_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: sampled mid-cycle, reflects what the next rising edge sees.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_ok || frame_drop) chk("pulse_excl", 32'(frame_ok & frame_drop), 0);
      if (prev_stall) chk("hold", {brx_valid, brx_last, brx_data}, {1'b1, prev_out});
      if (brx_valid && brx_ready) begin
        xfers++;
        if (sb_q.size() == 0) chk("unexpected_out", {brx_last, brx_data}, 32'h1000);
        else chk("out_byte", {brx_last, brx_data}, sb_q.pop_front());
      end
      prev_stall = brx_valid && !brx_ready;
      prev_out   = {brx_last, brx_data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("rst_outs", {brx_valid, brx_data, brx_last, frame_ok, frame_drop}, 0);
    chk("rst_cnts", {ok_count, drop_count}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drives one byte per cycle; returns just after the edge that samples the last byte.
  task automatic send_frame(input int len, input logic [7:0] base, input logic [7:0] step,
                            input bit user, input bit exp_ok);
    logic [7:0] d;
    d = base;
    for (int i = 0; i < len; i++) begin
      if (exp_ok) sb_q.push_back({(i == len - 1), d});
      rx_valid = 1'b1;
      rx_data  = d;
      rx_last  = (i == len - 1);
      rx_user  = user;
      @(posedge clk);
      #1;
      d = d + step;
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_user  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || brx_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", 32'(n < 300), 1);
  endtask

  initial begin
    do_reset();

    // Good frame and commit latency
    brx_ready = 1'b1;
    send_frame(4, 8'h11, 8'h11, 1'b0, 1'b1);
    chk("t1_ok_pulse", frame_ok, 1);
    chk("t1_valid_lag", brx_valid, 0);
    @(posedge clk); #1;
    chk("t1_valid_rise", {brx_valid, brx_data}, 9'h111);
    chk("t1_ok_one_cycle", frame_ok, 0);
    wait_drain();
    chk("t1_ok_count", ok_count, 1);

    // Bad frame then good frame
    do_reset();
    send_frame(5, 8'h50, 8'h01, 1'b1, 1'b0);
    chk("t2_drop_pulse", {frame_drop, frame_ok}, 2'b10);
    send_frame(2, 8'hA0, 8'h01, 1'b0, 1'b1);
    wait_drain();
    chk("t2_ok_count", ok_count, 1);
    chk("t2_drop_count", drop_count, 1);

    // Overflow: oversize frame dropped, exactly-SIZE frame fits
    do_reset();
    brx_ready = 1'b0;
    send_frame(SIZE + 4, 8'h00, 8'h01, 1'b0, 1'b0);
    chk("t3_drop_pulse", frame_drop, 1);
    @(posedge clk); #1;
    chk("t3_no_valid", brx_valid, 0);
    chk("t3_drop_count", drop_count, 1);
    send_frame(SIZE, 8'h40, 8'h01, 1'b0, 1'b1);
    chk("t3_ok_pulse", frame_ok, 1);
    repeat (3) @(posedge clk);
    #1;
    xfers = 0;
    brx_ready = 1'b1;
    wait_drain();
    chk("t3_xfers", xfers, SIZE);
    chk("t3_ok_count", ok_count, 1);

    // Backpressure: ready toggles every cycle
    do_reset();
    xfers = 0;
    brx_ready = 1'b0;
    fork
      send_frame(8, 8'hC0, 8'h03, 1'b0, 1'b1);
      begin
        repeat (40) begin
          @(posedge clk); #1;
          brx_ready = ~brx_ready;
        end
      end
    join
    brx_ready = 1'b1;
    wait_drain();
    chk("t4_xfers", xfers, 8);

    // Wrap: 10 back-to-back 7-byte frames
    do_reset();
    xfers = 0;
    for (int k = 0; k < 10; k++) send_frame(7, 8'(k * 7), 8'h01, 1'b0, 1'b1);
    wait_drain();
    chk("t5_xfers", xfers, 70);
    chk("t5_ok_count", ok_count, 10);
    chk("t5_drop_count", drop_count, 0);

    // Reset mid-frame, with unread committed data pending
    do_reset();
    brx_ready = 1'b0;
    send_frame(3, 8'h70, 8'h01, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1; rx_data = 8'h80 + 8'(i); rx_last = 1'b0;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    do_reset();
    brx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_stale_valid", {brx_valid, frame_ok, frame_drop}, 0);
    send_frame(2, 8'h5A, 8'h01, 1'b0, 1'b1);
    wait_drain();
    chk("t6_ok_count", ok_count, 1);
    chk("t6_drop_count", drop_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
